// File: rtl/uart_tx_arb.sv
// uart_tx_arb: two-requester, frame-granular arbiter in front of a single
// UART transmitter. Once a requester wins, it owns the transmitter for its
// whole frame. A frame is the run of bytes up to the one flagged "last".
// Each byte is handed to the transmitter with a one-cycle tx_en pulse.
// The arbiter then waits for tx_done before loading the next byte.
// Between frames a fixed idle gap is inserted. Ties are broken by a
// round-robin pointer that flips to the other requester after every
// completed or timed-out frame.
//
// Ports:
//   sys_clk, sys_rst          clock, asynchronous active-high reset
//   reqN_valid/data/last      requester N byte offer (N = 0, 1)
//   reqN_ready                requester N byte taken (combinational, LOAD only)
//   tx_data, tx_en            registered byte and start pulse to the transmitter
//   tx_done                   transmitter stop-bit-complete pulse
//   grant                     one-hot current owner, 00 when unowned
//   frame_done                one-cycle pulse on the owner's bit at frame end
//   timeout_err               one-cycle pulse when a tx_done wait expires
module uart_tx_arb #(
  parameter int unsigned GAP_CYCLES  = 16,
  parameter int unsigned TIMEOUT_CYC = 60000
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  input  logic       req0_last,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  input  logic       req1_last,
  output logic       req1_ready,
  output logic [7:0] tx_data,
  output logic       tx_en,
  input  logic       tx_done,
  output logic [1:0] grant,
  output logic [1:0] frame_done,
  output logic       timeout_err
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD      = 2'd1,
    WAIT_DONE = 2'd2,
    GAP       = 2'd3
  } state_t;

  localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYC - 1);
  localparam logic [31:0] GAP_LAST = 32'(GAP_CYCLES - 1);
  // With no gap configured, a finished or abandoned frame goes straight back
  // to arbitration.
  localparam state_t FRAME_END = (GAP_CYCLES == 0) ? IDLE : GAP;

  state_t      state_q;
  state_t      state_d;
  logic [31:0] cnt_q;
  logic        ptr_q;     // 1: requester 1 wins a tie, 0: requester 0 wins
  logic        last_q;    // the byte in flight closes the frame
  logic        hs;
  logic        pick1;
  logic        tmo_hit;

  assign hs      = (req0_valid & req0_ready) | (req1_valid & req1_ready);
  // A lone valid requester wins regardless of the pointer.
  assign pick1   = req1_valid & (~req0_valid | ptr_q);
  // tx_done in the expiry cycle takes priority, so expiry requires its absence.
  assign tmo_hit = ~tx_done & (cnt_q == TMO_LAST);

  // State register
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (req0_valid | req1_valid) state_d = LOAD;
      LOAD:      if (hs) state_d = WAIT_DONE;
      WAIT_DONE: begin
        if (tx_done) begin
          state_d = last_q ? FRAME_END : LOAD;
        end else if (tmo_hit) begin
          state_d = FRAME_END;
        end
      end
      GAP:       if (cnt_q == GAP_LAST) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Output logic: only the owner sees ready, and only while a byte is wanted.
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (state_q == LOAD) begin
      req0_ready = grant[0];
      req1_ready = grant[1];
    end
  end

  // Registered outputs, pointer and per-state counter
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      cnt_q       <= '0;
      ptr_q       <= 1'b0;
      last_q      <= 1'b0;
      grant       <= '0;
      tx_data     <= '0;
      tx_en       <= 1'b0;
      frame_done  <= '0;
      timeout_err <= 1'b0;
    end else begin
      tx_en       <= 1'b0;
      frame_done  <= '0;
      timeout_err <= 1'b0;

      // The counter restarts on every state change, so in WAIT_DONE and GAP
      // it holds the number of cycles spent in the current visit.
      if (state_d != state_q) begin
        cnt_q <= '0;
      end else if (state_q == WAIT_DONE || state_q == GAP) begin
        cnt_q <= cnt_q + 32'd1;
      end

      case (state_q)
        IDLE: begin
          if (req0_valid | req1_valid) grant <= pick1 ? 2'b10 : 2'b01;
        end
        LOAD: begin
          if (hs) begin
            tx_data <= grant[1] ? req1_data : req0_data;
            last_q  <= grant[1] ? req1_last : req0_last;
            tx_en   <= 1'b1;
          end
        end
        WAIT_DONE: begin
          if (tx_done) begin
            if (last_q) begin
              frame_done <= grant;
              ptr_q      <= grant[0];
              grant      <= '0;
            end
          end else if (tmo_hit) begin
            // Bytes the owner has not yet offered are arbitrated later as a
            // fresh frame.
            timeout_err <= 1'b1;
            ptr_q       <= grant[0];
            grant       <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arb.sv
// Testbench for uart_tx_arb: requester drivers feed byte queues, a simple
// transmitter model answers tx_en with tx_done, and a scoreboard of expected
// {byte, grant} and frame owners is consumed as the DUT produces them.
module tb_uart_tx_arb;

  localparam int GAP = 16;
  localparam int TMO = 20;

  typedef struct {
    int         req;
    logic [7:0] data;
    logic       last;
    logic [1:0] gnt;
  } vec_t;

  logic       sys_clk = 1'b0;
  logic       sys_rst = 1'b1;
  logic       req0_valid, req0_last, req0_ready;
  logic       req1_valid, req1_last, req1_ready;
  logic [7:0] req0_data, req1_data, tx_data;
  logic       tx_en, tx_done, tx_done_auto, tx_done_man;
  logic [1:0] grant, frame_done;
  logic       timeout_err;

  logic [9:0] exp_q[$];   // {tx_data, grant} per expected tx_en
  logic [1:0] fq[$];      // expected frame_done values in order
  logic [8:0] src0[$];    // {data, last} offered by requester 0
  logic [8:0] src1[$];
  int         rd0, rd1;
  logic       acc0, acc1;
  bit         auto_done;
  int         total, bad, n_tmo;

  assign tx_done = tx_done_auto | tx_done_man;

  always #5 sys_clk = ~sys_clk;

  uart_tx_arb #(.GAP_CYCLES(GAP), .TIMEOUT_CYC(TMO)) dut (
    .sys_clk     (sys_clk),
    .sys_rst     (sys_rst),
    .req0_valid  (req0_valid),
    .req0_data   (req0_data),
    .req0_last   (req0_last),
    .req0_ready  (req0_ready),
    .req1_valid  (req1_valid),
    .req1_data   (req1_data),
    .req1_last   (req1_last),
    .req1_ready  (req1_ready),
    .tx_data     (tx_data),
    .tx_en       (tx_en),
    .tx_done     (tx_done),
    .grant       (grant),
    .frame_done  (frame_done),
    .timeout_err (timeout_err)
  );

  // Handshakes seen at the clock edge, consumed by the drivers below.
  always @(posedge sys_clk) begin
    acc0 <= req0_valid & req0_ready;
    acc1 <= req1_valid & req1_ready;
  end

  initial begin
    rd0 = 0; req0_valid = 1'b0; req0_data = '0; req0_last = 1'b0;
    forever begin
      @(negedge sys_clk);
      if (acc0 === 1'b1) rd0++;
      if (rd0 < src0.size()) begin
        req0_valid = 1'b1;
        {req0_data, req0_last} = src0[rd0];
      end else begin
        req0_valid = 1'b0;
      end
    end
  end

  initial begin
    rd1 = 0; req1_valid = 1'b0; req1_data = '0; req1_last = 1'b0;
    forever begin
      @(negedge sys_clk);
      if (acc1 === 1'b1) rd1++;
      if (rd1 < src1.size()) begin
        req1_valid = 1'b1;
        {req1_data, req1_last} = src1[rd1];
      end else begin
        req1_valid = 1'b0;
      end
    end
  end

  // Transmitter model: stop bit completes three cycles after tx_en.
  initial begin
    tx_done_auto = 1'b0;
    forever begin
      @(negedge sys_clk);
      if (tx_en === 1'b1 && auto_done) begin
        repeat (2) @(negedge sys_clk);
        tx_done_auto = 1'b1;
        @(negedge sys_clk);
        tx_done_auto = 1'b0;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    logic [9:0] e;
    @(negedge sys_clk);
    if (tx_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL tx_en: unexpected byte %02h grant %b, none expected", tx_data, grant);
      end else begin
        e = exp_q.pop_front();
        chk("tx_data", 32'(tx_data), 32'(e[9:2]));
        chk("tx_grant", 32'(grant), 32'(e[1:0]));
      end
    end
    if (frame_done !== 2'b00) begin
      if (fq.size() == 0) begin
        total++; bad++;
        $display("FAIL frame_done: unexpected pulse %b, none expected", frame_done);
      end else begin
        chk("frame_done", 32'(frame_done), 32'(fq.pop_front()));
      end
    end
    if (timeout_err === 1'b1) n_tmo++;
  endtask

  task automatic push_byte(input int r, input logic [7:0] d, input logic l,
                           input logic [1:0] g, input logic fr);
    if (r == 0) src0.push_back({d, l});
    else        src1.push_back({d, l});
    exp_q.push_back({d, g});
    if (fr) fq.push_back(g);
  endtask

  task automatic wait_txen(input string name);
    int k = 0;
    while (tx_en !== 1'b1 && k < 50) begin tick(); k++; end
    total++;
    if (tx_en !== 1'b1) begin
      bad++;
      $display("FAIL %s: tx_en never rose within %0d cycles", name, k);
    end
  endtask

  task automatic wait_drain(input string name, input int budget);
    int k = 0;
    while ((exp_q.size() != 0 || fq.size() != 0) && k < budget) begin tick(); k++; end
    total++;
    if (exp_q.size() != 0 || fq.size() != 0) begin
      bad++;
      $display("FAIL %s: %0d bytes and %0d frames still pending after %0d cycles",
               name, exp_q.size(), fq.size(), k);
    end
    repeat (GAP + 3) tick();
  endtask

  initial begin
    vec_t tbl[9];
    int   k;
    logic gap_bad;

    tbl[0] = '{0, 8'hA5, 1'b1, 2'b01};
    tbl[1] = '{1, 8'h11, 1'b0, 2'b10};
    tbl[2] = '{1, 8'h22, 1'b0, 2'b10};
    tbl[3] = '{1, 8'h33, 1'b1, 2'b10};
    tbl[4] = '{0, 8'hC3, 1'b1, 2'b01};
    tbl[5] = '{1, 8'h44, 1'b1, 2'b10};
    tbl[6] = '{0, 8'h01, 1'b0, 2'b01};
    tbl[7] = '{0, 8'h02, 1'b1, 2'b01};
    tbl[8] = '{1, 8'hFF, 1'b1, 2'b10};

    total = 0; bad = 0; n_tmo = 0;
    auto_done = 1'b1;
    tx_done_man = 1'b0;

    // Reset values
    tick(); tick();
    chk("rst_tx_data", 32'(tx_data), 32'h00);
    chk("rst_tx_en", 32'(tx_en), 32'h0);
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_ready", 32'({req1_ready, req0_ready}), 32'h0);
    chk("rst_frame_done", 32'(frame_done), 32'h0);
    chk("rst_timeout", 32'(timeout_err), 32'h0);
    sys_rst = 1'b0;
    tick();

    // Spurious tx_done while idle
    tx_done_man = 1'b1;
    tick();
    tx_done_man = 1'b0;
    tick(); tick();
    chk("idle_spur_grant", 32'(grant), 32'h0);
    chk("idle_spur_pulses", 32'({frame_done, timeout_err}), 32'h0);

    // Single-byte frame: latency, frame_done, gap length, lone winner
    @(posedge sys_clk); #1;
    push_byte(0, 8'hA5, 1'b1, 2'b01, 1'b1);
    tick();
    tick();
    chk("lat_ready0", 32'(req0_ready), 32'h1);
    chk("lat_ready1", 32'(req1_ready), 32'h0);
    chk("lat_grant", 32'(grant), 32'h1);
    tick();
    chk("lat_tx_en", 32'(tx_en), 32'h1);
    k = 0;
    while (frame_done === 2'b00 && k < 20) begin tick(); k++; end
    chk("single_frame_seen", 32'(k < 20), 32'h1);
    chk("gap_grant", 32'(grant), 32'h0);
    @(posedge sys_clk); #1;
    push_byte(0, 8'h5A, 1'b1, 2'b01, 1'b1);
    k = 0; gap_bad = 1'b0;
    while (grant === 2'b00 && k < 40) begin
      tick(); k++;
      tx_done_man = (k == 3);
      if (k <= GAP && (req0_ready | req1_ready)) gap_bad = 1'b1;
    end
    tx_done_man = 1'b0;
    chk("gap_len", 32'(k), 32'(GAP + 1));
    chk("gap_ready", 32'(gap_bad), 32'h0);
    chk("lone_winner", 32'(grant), 32'h1);
    wait_drain("lone_frame", 200);

    // Table: both requesters loaded together, frames must alternate
    sys_rst = 1'b1;
    tick();
    sys_rst = 1'b0;
    @(posedge sys_clk); #1;
    for (int i = 0; i < 9; i++)
      push_byte(tbl[i].req, tbl[i].data, tbl[i].last, tbl[i].gnt, tbl[i].last);
    wait_drain("table", 3000);

    // tx_done withheld: timeout
    auto_done = 1'b0;
    @(posedge sys_clk); #1;
    push_byte(1, 8'h77, 1'b1, 2'b10, 1'b0);
    wait_txen("tmo_txen");
    k = 0;
    while (timeout_err !== 1'b1 && k < 60) begin tick(); k++; end
    chk("tmo_latency", 32'(k), 32'(TMO));
    chk("tmo_grant", 32'(grant), 32'h0);
    chk("tmo_ready", 32'({req1_ready, req0_ready}), 32'h0);
    repeat (GAP + 3) tick();

    // tx_done in the expiry cycle wins over the timeout
    @(posedge sys_clk); #1;
    push_byte(0, 8'h88, 1'b1, 2'b01, 1'b1);
    wait_txen("tie_txen");
    repeat (TMO - 1) tick();
    tx_done_man = 1'b1;
    tick();
    tx_done_man = 1'b0;
    chk("tie_no_err", 32'(timeout_err), 32'h0);
    chk("tie_frame_done", 32'(frame_done), 32'h1);
    repeat (GAP + 3) tick();

    // Reset in WAIT_DONE of a 2-byte frame while the pointer favours req1
    @(posedge sys_clk); #1;
    push_byte(0, 8'hB1, 1'b0, 2'b01, 1'b0);
    push_byte(0, 8'hB2, 1'b1, 2'b01, 1'b1);
    wait_txen("rst_frame_txen");
    repeat (3) tick();
    #2 sys_rst = 1'b1;
    #1;
    chk("async_tx_data", 32'(tx_data), 32'h00);
    chk("async_grant", 32'(grant), 32'h0);
    chk("async_ready", 32'({req1_ready, req0_ready}), 32'h0);
    @(posedge sys_clk); #1;
    push_byte(1, 8'hD4, 1'b1, 2'b10, 1'b1);
    tick();
    chk("rst_no_pulse", 32'({frame_done, timeout_err}), 32'h0);
    tick();
    auto_done = 1'b1;
    sys_rst = 1'b0;
    wait_txen("post_rst_txen");
    chk("post_rst_winner", 32'(grant), 32'h1);
    wait_drain("post_rst", 400);

    chk("sb_empty", 32'(exp_q.size()), 32'h0);
    chk("fq_empty", 32'(fq.size()), 32'h0);
    chk("timeout_count", 32'(n_tmo), 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
